// File: rtl/glb_pe_pkg.sv
// Shared types and tag-match helper for the global PE node.
package glb_pe_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_PSUM, S_OUT} state_e;
  typedef enum logic {KIND_IFMAP = 1'b0, KIND_FILTER = 1'b1} kind_e;

  // Tags are zero-extended to this width so one helper serves any ID_WIDTH.
  localparam int unsigned ID_MAX_W = 16;
  localparam logic [ID_MAX_W-1:0] BCAST_ID = '1;

  function automatic logic id_match(input logic [ID_MAX_W-1:0] tag,
                                    input logic [ID_MAX_W-1:0] mine,
                                    input int unsigned         width);
    logic [ID_MAX_W-1:0] bcast;
    bcast = BCAST_ID >> (ID_MAX_W - width);
    return (tag == mine) || (tag == bcast);
  endfunction

endpackage

// File: rtl/pe_operand_fifo.sv
// Operand FIFO with first-word-fall-through read port and synchronous reset.
module pe_operand_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/glb_pe_mc.sv
// Global PE: tagged multicast capture into operand FIFOs, K-long MAC, psum add.
// Define GLB_PE_SAT_EN for saturating arithmetic and the sticky sat_flag output.
module glb_pe_mc
  import glb_pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned K_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [ID_WIDTH-1:0]   cfg_row_id,
  input  logic [ID_WIDTH-1:0]   cfg_col_id,
  input  logic [K_WIDTH-1:0]    cfg_klen,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic                  bus_ready_all,
  input  logic                  bus_kind,
  input  logic [ID_WIDTH-1:0]   bus_row_id,
  input  logic [ID_WIDTH-1:0]   bus_col_id,
  input  logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [ACC_WIDTH-1:0]  psum_in_data,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [ACC_WIDTH-1:0]  psum_out_data,
  output logic                  busy
`ifdef GLB_PE_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  state_e                        state, state_next;
  logic [ID_WIDTH-1:0]           row_id, col_id;
  logic [K_WIDTH-1:0]            klen, cnt;
  logic [ACC_WIDTH-1:0]          acc;
  logic                          hit, kind_full, bus_fire, pop, last_pair;
  logic                          if_full, if_empty, fl_full, fl_empty;
  logic [DATA_WIDTH-1:0]         if_rdata, fl_rdata;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]          prod_ext, mac_sum, psum_sum;
  kind_e                         kind;

  assign kind = kind_e'(bus_kind);
  assign hit  = id_match(ID_MAX_W'(bus_row_id), ID_MAX_W'(row_id), ID_WIDTH)
              & id_match(ID_MAX_W'(bus_col_id), ID_MAX_W'(col_id), ID_WIDTH);

  // A PE that is not addressed must never hold back the shared bus.
  assign kind_full = (kind == KIND_FILTER) ? fl_full : if_full;
  assign bus_ready = ~hit | ~kind_full;
  assign bus_fire  = bus_valid & bus_ready_all & hit;

  pe_operand_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus_fire & (kind == KIND_IFMAP)),
    .wdata (bus_data),
    .pop   (pop),
    .rdata (if_rdata),
    .full  (if_full),
    .empty (if_empty)
  );

  pe_operand_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_filter_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus_fire & (kind == KIND_FILTER)),
    .wdata (bus_data),
    .pop   (pop),
    .rdata (fl_rdata),
    .full  (fl_full),
    .empty (fl_empty)
  );

  assign pop       = (state == S_ACC) & ~if_empty & ~fl_empty;
  assign last_pair = ((cnt + K_WIDTH'(1)) == klen);
  assign prod      = $signed(if_rdata) * $signed(fl_rdata);
  assign prod_ext  = ACC_WIDTH'(prod);

`ifdef GLB_PE_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] mac_wide, psum_wide;
  logic               mac_ovf, psum_ovf;

  // One guard bit: overflow whenever it disagrees with the result sign.
  assign mac_wide  = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign psum_wide = {acc[ACC_WIDTH-1], acc} + {psum_in_data[ACC_WIDTH-1], psum_in_data};
  assign mac_ovf   = mac_wide[ACC_WIDTH] ^ mac_wide[ACC_WIDTH-1];
  assign psum_ovf  = psum_wide[ACC_WIDTH] ^ psum_wide[ACC_WIDTH-1];
  assign mac_sum   = mac_ovf  ? (mac_wide[ACC_WIDTH]  ? ACC_MIN : ACC_MAX) : mac_wide[ACC_WIDTH-1:0];
  assign psum_sum  = psum_ovf ? (psum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : psum_wide[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (psum_out_valid & psum_out_ready) begin
      sat_flag <= 1'b0;
    end else if ((pop & mac_ovf) | (psum_in_valid & psum_in_ready & psum_ovf)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign mac_sum  = acc + prod_ext;
  assign psum_sum = acc + psum_in_data;
`endif

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    unique case (state)
      S_IDLE: if (cfg_valid) state_next = S_ACC;
      S_ACC:  if (pop && last_pair) state_next = S_PSUM;
      S_PSUM: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) state_next = S_OUT;
      end
      S_OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) state_next = S_ACC;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      row_id        <= '0;
      col_id        <= '0;
      klen          <= K_WIDTH'(1);
      cnt           <= '0;
      acc           <= '0;
      psum_out_data <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: if (cfg_valid) begin
          row_id <= cfg_row_id;
          col_id <= cfg_col_id;
          klen   <= (cfg_klen == '0) ? K_WIDTH'(1) : cfg_klen;
        end
        S_ACC: if (pop) begin
          acc <= mac_sum;
          cnt <= last_pair ? '0 : cnt + K_WIDTH'(1);
        end
        S_PSUM: if (psum_in_valid) begin
          psum_out_data <= psum_sum;
          acc           <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_pe_mc.sv
// Self-checking bench for glb_pe_mc: directed scenarios plus randomized traffic vs a queue model.
module tb_glb_pe_mc;

  localparam int DW = 16;
`ifdef GLB_PE_SAT_EN
  localparam int AW = 32;
`else
  localparam int AW = 40;
`endif
  localparam int IW = 4;
  localparam int FD = 4;
  localparam int KW = 8;
  localparam longint ACC_MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint ACC_MINV = -(64'sd1 <<< (AW-1));

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [IW-1:0] cfg_row_id, cfg_col_id;
  logic [KW-1:0] cfg_klen;
  logic          bus_valid, bus_ready, bus_ready_all, bus_kind, other_ready;
  logic [IW-1:0] bus_row_id, bus_col_id;
  logic [DW-1:0] bus_data;
  logic          psum_in_valid, psum_in_ready;
  logic [AW-1:0] psum_in_data;
  logic          psum_out_valid, psum_out_ready;
  logic [AW-1:0] psum_out_data;
  logic          busy;
`ifdef GLB_PE_SAT_EN
  logic          sat_flag;
`endif

  // Single PE stands in for the array; other_ready models the rest of it.
  assign bus_ready_all = bus_ready & other_ready;

  always #5 clk = ~clk;

  glb_pe_mc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(FD), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_row_id(cfg_row_id), .cfg_col_id(cfg_col_id), .cfg_klen(cfg_klen),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_ready_all(bus_ready_all), .bus_kind(bus_kind),
    .bus_row_id(bus_row_id), .bus_col_id(bus_col_id), .bus_data(bus_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .busy(busy)
`ifdef GLB_PE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            mq_if[$];
  int            mq_fl[$];
  longint        m_acc;
  int            m_cnt, m_klen, m_phase;  // phase: 0 idle, 1 accumulate, 2 await psum, 3 result out
  logic [IW-1:0] m_row, m_col;
  logic [AW-1:0] m_out;
  bit            m_sat;

  function automatic void m_reset();
    mq_if.delete();
    mq_fl.delete();
    m_acc = 0; m_cnt = 0; m_klen = 1; m_phase = 0;
    m_row = '0; m_col = '0; m_out = '0; m_sat = 0;
  endfunction

  function automatic bit m_tag(input logic [IW-1:0] t, input logic [IW-1:0] me);
    return (t == me) || (t == {IW{1'b1}});
  endfunction

  function automatic bit m_hit();
    return m_tag(bus_row_id, m_row) && m_tag(bus_col_id, m_col);
  endfunction

  function automatic bit m_ready();
    int n;
    n = bus_kind ? mq_fl.size() : mq_if.size();
    return !m_hit() || (n < FD);
  endfunction

  function automatic longint m_fix(input longint v);
`ifdef GLB_PE_SAT_EN
    if (v > ACC_MAXV) begin m_sat = 1; return ACC_MAXV; end
    if (v < ACC_MINV) begin m_sat = 1; return ACC_MINV; end
    return v;
`else
    longint w;
    w = v & ((64'sd1 <<< AW) - 1);
    if (w[AW-1]) w = w - (64'sd1 <<< AW);
    return w;
`endif
  endfunction

  function automatic void m_step();
    bit     do_push;
    int     a, b;
    longint p;
    if (rst) begin
      m_reset();
      return;
    end
    do_push = bus_valid && other_ready && m_ready() && m_hit();
    case (m_phase)
      0: if (cfg_valid) begin
        m_row = cfg_row_id; m_col = cfg_col_id;
        m_klen = (cfg_klen == 0) ? 1 : int'(cfg_klen);
        m_phase = 1;
      end
      1: if (mq_if.size() > 0 && mq_fl.size() > 0) begin
        a = mq_if.pop_front();
        b = mq_fl.pop_front();
        m_acc = m_fix(m_acc + longint'(a) * longint'(b));
        m_cnt++;
        if (m_cnt == m_klen) begin m_cnt = 0; m_phase = 2; end
      end
      2: if (psum_in_valid) begin
        p = $signed(psum_in_data);
        m_out = AW'(m_fix(m_acc + p));
        m_acc = 0;
        m_phase = 3;
      end
      default: if (psum_out_ready) begin m_phase = 1; m_sat = 0; end
    endcase
    if (do_push) begin
      if (bus_kind) mq_fl.push_back(int'($signed(bus_data)));
      else          mq_if.push_back(int'($signed(bus_data)));
    end
  endfunction

  // Compare process: outputs checked against the model on every falling edge.
  initial begin
    m_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("bus_ready", 64'(bus_ready), 64'(m_ready()));
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("psum_in_ready", 64'(psum_in_ready), 64'(m_phase == 2));
      check("psum_out_valid", 64'(psum_out_valid), 64'(m_phase == 3));
      check("psum_out_data", 64'(psum_out_data), 64'(m_out));
`ifdef GLB_PE_SAT_EN
      check("sat_flag", 64'(sat_flag), 64'(m_sat));
`endif
      m_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [IW-1:0] r, input logic [IW-1:0] c, input logic [KW-1:0] k);
    cfg_row_id = r; cfg_col_id = c; cfg_klen = k; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input bit kind, input logic [IW-1:0] r, input logic [IW-1:0] c,
                      input logic [DW-1:0] d);
    bit fired;
    bus_kind = kind; bus_row_id = r; bus_col_id = c; bus_data = d; bus_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      fired = bus_ready_all;
      tick();
      if (fired) begin
        bus_valid = 1'b0;
        return;
      end
      other_ready = 1'b1;
    end
    check("send_timeout", 64'd0, 64'd1);
    bus_valid = 1'b0;
  endtask

  task automatic psum_give(input logic [AW-1:0] d);
    bit fired;
    psum_in_data = d; psum_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      fired = psum_in_ready;
      tick();
      if (fired) begin
        psum_in_valid = 1'b0;
        return;
      end
    end
    check("psum_in_timeout", 64'd0, 64'd1);
    psum_in_valid = 1'b0;
  endtask

  // Leaves the bench at the falling edge where the result is first seen.
  task automatic wait_out(input string name, input logic [AW-1:0] exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psum_out_valid) begin
        check(name, 64'(psum_out_data), 64'(exp));
        check({name, "_model"}, 64'(m_out), 64'(exp));
        return;
      end
    end
    check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic release_out(input string name, input logic [AW-1:0] exp);
    repeat (2) begin
      @(negedge clk);
      check({name, "_held_valid"}, 64'(psum_out_valid), 64'd1);
      check({name, "_held_data"}, 64'(psum_out_data), 64'(exp));
    end
    tick();
    psum_out_ready = 1'b1;
    tick();
    psum_out_ready = 1'b0;
    @(negedge clk);
    check({name, "_one_pulse"}, 64'(psum_out_valid), 64'd0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]    tags [6];
  logic [AW-1:0] exp_v;
  bit            bus_fired, pin_fired;
  int            ti;

  initial begin
    tags = '{8'h21, 8'hFF, 8'hF1, 8'h2F, 8'h31, 8'h20};
    rst = 1'b1; cfg_valid = 0; cfg_row_id = 0; cfg_col_id = 0; cfg_klen = 0;
    bus_valid = 0; bus_kind = 0; bus_row_id = 0; bus_col_id = 0; bus_data = 0; other_ready = 1;
    psum_in_valid = 0; psum_in_data = 0; psum_out_ready = 0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bus_ready", 64'(bus_ready), 64'd1);
    check("rst_out_valid", 64'(psum_out_valid), 64'd0);
    check("rst_in_ready", 64'(psum_in_ready), 64'd0);
    check("rst_out_data", 64'(psum_out_data), 64'd0);
    tick();
    rst = 1'b0;

    // 1: 1*4 + 2*5 + 3*6 + 10 = 42
    cfg(4'd2, 4'd1, 8'd3);
    send(0, 4'd2, 4'd1, 16'd1); send(1, 4'd2, 4'd1, 16'd4);
    send(0, 4'd2, 4'd1, 16'd2); send(1, 4'd2, 4'd1, 16'd5);
    send(0, 4'd2, 4'd1, 16'd3); send(1, 4'd2, 4'd1, 16'd6);
    psum_give(AW'(10));
    wait_out("t1_psum_out", AW'(42));
    release_out("t1", AW'(42));

    // 3 & 2: fill ifmap FIFO, with a foreign-tagged word in between that must not land
    send(0, 4'd2, 4'd1, 16'd1); send(0, 4'd2, 4'd1, 16'd2); send(0, 4'd2, 4'd1, 16'd3);
    bus_kind = 0; bus_row_id = 4'd3; bus_col_id = 4'd1; bus_data = 16'd99; bus_valid = 1'b1;
    @(negedge clk);
    check("t2_foreign_ready", 64'(bus_ready), 64'd1);
    tick();
    bus_valid = 1'b0;
    send(0, 4'd2, 4'd1, 16'd4);
    bus_kind = 0; bus_row_id = 4'd2; bus_col_id = 4'd1;
    @(negedge clk);
    check("t3_ready_ifmap_full", 64'(bus_ready), 64'd0);
    tick();
    bus_kind = 1;
    @(negedge clk);
    check("t3_ready_filter", 64'(bus_ready), 64'd1);
    tick();
    send(1, 4'd2, 4'd1, 16'd5);
    bus_kind = 0;
    @(negedge clk);
    check("t3_ready_before_pop", 64'(bus_ready), 64'd0);
    tick();
    @(negedge clk);
    check("t3_ready_after_pop", 64'(bus_ready), 64'd1);
    tick();
    // broadcast-tagged filter is captured: 1*5 + 2*6 + 3*7 = 38
    send(1, 4'hF, 4'hF, 16'd6);
    send(1, 4'd2, 4'd1, 16'd7);
    psum_give(AW'(0));
    wait_out("t2_psum_out", AW'(38));
    release_out("t2", AW'(38));

    // 5: reset mid-window with cnt = 2 and an ifmap word still queued
    send(1, 4'd2, 4'd1, 16'd10);
    send(0, 4'd2, 4'd1, 16'd2);
    send(1, 4'd2, 4'd1, 16'd2);
    send(0, 4'd2, 4'd1, 16'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_out_valid", 64'(psum_out_valid), 64'd0);
    check("t5_bus_ready", 64'(bus_ready), 64'd1);
    tick();

    // 4: klen 0 behaves as 1; a leftover word from before reset would corrupt -21
    cfg(4'd2, 4'd1, 8'd0);
    send(0, 4'd2, 4'd1, 16'hFFF9);
    send(1, 4'd2, 4'd1, 16'd3);
    psum_give(AW'(0));
    exp_v = AW'(-21);
    wait_out("t4_psum_out", exp_v);
    release_out("t4", exp_v);

    // 6: near-max psum plus 0x7FFF*0x7FFF
    send(0, 4'd2, 4'd1, 16'h7FFF);
    send(1, 4'd2, 4'd1, 16'h7FFF);
    psum_give(AW'(ACC_MAXV - 15));
`ifdef GLB_PE_SAT_EN
    exp_v = AW'(ACC_MAXV);
`else
    exp_v = AW'(ACC_MAXV - 15 + 64'sh3FFF0001);
`endif
    wait_out("t6_psum_out", exp_v);
`ifdef GLB_PE_SAT_EN
    check("t6_sat_flag", 64'(sat_flag), 64'd1);
`endif
    release_out("t6", exp_v);

    // randomized traffic, with one reset and reconfiguration halfway
    bus_fired = 0; pin_fired = 0;
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) begin
        bus_valid = 0; psum_in_valid = 0; psum_out_ready = 0; cfg_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg(4'd2, 4'd1, KW'($urandom_range(0, 4)));
        bus_fired = 0; pin_fired = 0;
      end
      if (!bus_valid || bus_fired) begin
        ti = $urandom_range(0, 5);
        bus_valid  = ($urandom_range(0, 3) != 0);
        bus_row_id = tags[ti][7:4];
        bus_col_id = tags[ti][3:0];
        bus_data   = DW'($urandom());
        if (mq_if.size() >= FD)      bus_kind = 1'b1;
        else if (mq_fl.size() >= FD) bus_kind = 1'b0;
        else                         bus_kind = 1'($urandom_range(0, 1));
      end
      other_ready = ($urandom_range(0, 3) != 0);
      if (!psum_in_valid || pin_fired) begin
        psum_in_valid = 1'($urandom_range(0, 1));
        psum_in_data  = AW'({$urandom(), $urandom()});
      end
      psum_out_ready = ($urandom_range(0, 2) != 0);
      cfg_valid  = ($urandom_range(0, 15) == 0);
      cfg_row_id = IW'($urandom());
      cfg_col_id = IW'($urandom());
      cfg_klen   = KW'($urandom());
      @(negedge clk);
      bus_fired = bus_valid && bus_ready_all;
      pin_fired = psum_in_valid && psum_in_ready;
      tick();
    end
    bus_valid = 0; psum_in_valid = 0; psum_out_ready = 0; cfg_valid = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
